nor_logic_unit: RTL
===================

// Module: nor_logic_unit
//
// PURPOSE
// - Parametrised, registered logic unit. Every function is built only from 2-input nor_gate primitives.
// - Successor to the single-function NOR gate networks: WIDTH-bit vectors, runtime op select,
//   a valid/ready handshake and an optional built-in self-test.
// - Sits between a requester and consumer as a one-stage pipeline element.
//
// PARAMETERS
// - WIDTH    8   bit width of a, b, y (>=1)
// - ST_CYCLES 28  self-test vector count, fixed at 7 ops x 4 input pairs; do not override
//
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      a/b/op beat valid
// - in_ready   out  1      unit can accept a beat
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - op         in   3      0 OR, 1 AND, 2 NAND, 3 XOR, 4 XNOR, 5 NOR, 6 NOT_A, 7 reserved
// - out_valid  out  1      y/op_err valid
// - out_ready  in   1      consumer accepts result
// - y          out  WIDTH  registered result
// - op_err     out  1      result beat came from reserved op 7
// - st_start   in   1      self-test request, single-cycle pulse
// - st_busy    out  1      self-test running
// - st_done    out  1      self-test finished, sticky until next st_start
// - st_pass    out  1      all self-test vectors matched, valid when st_done=1
//
// BEHAVIOUR
// - Reset (rst_n=0, async): y=0, op_err=0, out_valid=0, st_busy=0, st_done=0, st_pass=0, FSM=IDLE.
//
// - Datapath: per bit, pure nor_gate networks.
//   - OR = 2 gates; AND = 3; NAND = 4; XOR = 5; XNOR = 4; NOR = 1; NOT_A = 1 (a nor a).
//   - Only the op mux and registers are behavioural.
//
// - Handshake:
//   - in_ready = !st_busy && (!out_valid || out_ready).
//   - Accept on in_valid && in_ready. Result registers on that edge, so latency is 1 cycle.
//   - Full throughput is 1 beat/cycle while out_ready=1.
//   - out_valid holds and y/op_err stay stable until out_valid && out_ready.
//   - Simultaneous pop and accept in one cycle: the new beat replaces the old; no bubble.
//   - op=7: y=0, op_err=1, beat still handshakes normally.
//   - op_err is valid only while out_valid=1. Otherwise it is 0.
//
// - Self-test FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: st_start is honoured only when out_valid=0. Otherwise it is ignored, with no latching.
//     - When honoured: go to RUN, st_busy=1, st_done=0, st_pass preset 1, vector counter=0.
//   - RUN: one vector per cycle, 28 cycles.
//     - The counter drives the internal op (cnt/4) and the pair (pa, pb) = cnt%4.
//     - Each of pa and pb is replicated across WIDTH bits.
//     - The NOR network output is compared with a behavioural reference (|, &, ~&, ^, ~^, ~|, ~).
//     - Any mismatch clears st_pass, which stays cleared.
//     - After cnt=27, go to DONE.
//   - DONE (1 cycle): st_busy=0, st_done=1, then IDLE. st_done and st_pass hold.
//   - st_start during RUN or DONE is ignored.
//   - External a/b/op are ignored during RUN. out_valid stays 0 and y is not updated.
//   - Async reset mid-test: everything returns to reset values and st_done=0.
//
// CONFIGURATION
// - NOR_LU_SELFTEST_EN defined:
//   - Self-test FSM, vector counter and reference comparator are compiled in, as above.
// - NOR_LU_SELFTEST_EN undefined:
//   - st_start is ignored. st_busy, st_done and st_pass are tied 0.
//   - in_ready = !out_valid || out_ready.
//   - Port list is unchanged.
//
// TESTING
// - Reset: assert rst_n=0 mid-stream with out_valid=1 -> all outputs 0 immediately, asynchronously.
// - Op sweep, WIDTH=8, out_ready=1, a=8'hF0, b=8'hCC, op 0..6 on consecutive cycles:
//   - expected y = FC, C0, 3F, 3C, C3, 03, 0F, one cycle after each accept.
// - Backpressure: out_ready=0 with 2 beats offered:
//   - first beat held stable, in_ready=0, second beat stalls.
//   - Release out_ready -> second beat appears next cycle; no loss or duplication.
// - Reserved op: op=7, a=8'hFF, b=8'h00 -> y=8'h00, op_err=1 for one beat; next valid op gives op_err=0.
// - Self-test (macro on): pulse st_start when idle:
//   - st_busy=1 for 28 cycles, then st_done=1, st_pass=1.
//   - in_valid offered during the test is not accepted.
//   - Reset at cycle 10 -> st_busy=0, st_done=0.
// - Self-test (macro off): pulse st_start -> st_busy, st_done, st_pass remain 0; a concurrent beat is accepted normally.

Source files
------------

// File: rtl/nor_logic_unit.sv
// Registered WIDTH-bit logic unit built from 2-input NOR gates, with a valid/ready handshake.
// Built-in self-test is compiled in only when NOR_LU_SELFTEST_EN is defined.

module nor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a | b);
endmodule

module nor_logic_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ST_CYCLES = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             op_err,
  input  logic             st_start,
  output logic             st_busy,
  output logic             st_done,
  output logic             st_pass
);

  logic [WIDTH-1:0] net_a, net_b;
  logic [2:0]       net_op;
  logic [WIDTH-1:0] r_or, r_and, r_nand, r_xor, r_xnor, r_nor, r_not;
  logic [WIDTH-1:0] net_res;
  logic             accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic or_t;
    logic and_na, and_nb;
    logic nand_na, nand_nb, nand_t;
    logic xor_t1, xor_t2, xor_t3, xor_t4;
    logic xn_t1, xn_t2, xn_t3;

    nor_gate u_nor  (.a(net_a[i]), .b(net_b[i]), .y(r_nor[i]));

    nor_gate u_or0  (.a(net_a[i]), .b(net_b[i]), .y(or_t));
    nor_gate u_or1  (.a(or_t),     .b(or_t),     .y(r_or[i]));

    nor_gate u_and0 (.a(net_a[i]), .b(net_a[i]), .y(and_na));
    nor_gate u_and1 (.a(net_b[i]), .b(net_b[i]), .y(and_nb));
    nor_gate u_and2 (.a(and_na),   .b(and_nb),   .y(r_and[i]));

    nor_gate u_nand0 (.a(net_a[i]), .b(net_a[i]), .y(nand_na));
    nor_gate u_nand1 (.a(net_b[i]), .b(net_b[i]), .y(nand_nb));
    nor_gate u_nand2 (.a(nand_na),  .b(nand_nb),  .y(nand_t));
    nor_gate u_nand3 (.a(nand_t),   .b(nand_t),   .y(r_nand[i]));

    // XNOR core: x4 = (a & b) | (~a & ~b); XOR inverts it with one more gate
    nor_gate u_xor0 (.a(net_a[i]), .b(net_b[i]), .y(xor_t1));
    nor_gate u_xor1 (.a(net_a[i]), .b(xor_t1),   .y(xor_t2));
    nor_gate u_xor2 (.a(net_b[i]), .b(xor_t1),   .y(xor_t3));
    nor_gate u_xor3 (.a(xor_t2),   .b(xor_t3),   .y(xor_t4));
    nor_gate u_xor4 (.a(xor_t4),   .b(xor_t4),   .y(r_xor[i]));

    nor_gate u_xn0  (.a(net_a[i]), .b(net_b[i]), .y(xn_t1));
    nor_gate u_xn1  (.a(net_a[i]), .b(xn_t1),    .y(xn_t2));
    nor_gate u_xn2  (.a(net_b[i]), .b(xn_t1),    .y(xn_t3));
    nor_gate u_xn3  (.a(xn_t2),    .b(xn_t3),    .y(r_xnor[i]));

    nor_gate u_not  (.a(net_a[i]), .b(net_a[i]), .y(r_not[i]));
  end

  always_comb begin
    net_res = '0;
    case (net_op)
      3'd0:    net_res = r_or;
      3'd1:    net_res = r_and;
      3'd2:    net_res = r_nand;
      3'd3:    net_res = r_xor;
      3'd4:    net_res = r_xnor;
      3'd5:    net_res = r_nor;
      3'd6:    net_res = r_not;
      default: net_res = '0;
    endcase
  end

  assign in_ready = !st_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // The network is driven by the external operands whenever the self-test is not running,
  // so the op_err decode always uses the external op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      op_err    <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      y         <= net_res;
      op_err    <= (op == 3'd7);
      out_valid <= 1'b1;
    end else if (out_ready) begin
      op_err    <= 1'b0;
      out_valid <= 1'b0;
    end
  end

`ifdef NOR_LU_SELFTEST_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} st_state_t;

  localparam int unsigned CNT_W = 5;

  st_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] st_a, st_b, ref_res;

  assign st_a   = {WIDTH{cnt[1]}};
  assign st_b   = {WIDTH{cnt[0]}};
  assign net_a  = (state == ST_RUN) ? st_a : a;
  assign net_b  = (state == ST_RUN) ? st_b : b;
  assign net_op = (state == ST_RUN) ? cnt[4:2] : op;

  always_comb begin
    ref_res = '0;
    case (cnt[4:2])
      3'd0:    ref_res = st_a | st_b;
      3'd1:    ref_res = st_a & st_b;
      3'd2:    ref_res = ~(st_a & st_b);
      3'd3:    ref_res = st_a ^ st_b;
      3'd4:    ref_res = ~(st_a ^ st_b);
      3'd5:    ref_res = ~(st_a | st_b);
      3'd6:    ref_res = ~st_a;
      default: ref_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      st_busy <= 1'b0;
      st_done <= 1'b0;
      st_pass <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (st_start && !out_valid) begin
            state   <= ST_RUN;
            cnt     <= '0;
            st_busy <= 1'b1;
            st_done <= 1'b0;
            st_pass <= 1'b1;
          end
        end
        ST_RUN: begin
          if (net_res != ref_res) st_pass <= 1'b0;
          if (cnt == CNT_W'(ST_CYCLES - 1)) begin
            state   <= ST_DONE;
            st_busy <= 1'b0;
            st_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_st;

  assign net_a     = a;
  assign net_b     = b;
  assign net_op    = op;
  assign st_busy   = 1'b0;
  assign st_done   = 1'b0;
  assign st_pass   = 1'b0;
  assign unused_st = st_start ^ (ST_CYCLES == 0);
`endif

endmodule
